piano_synth_poly: RTL and testbench

//  Polyphonic successor to the single-voice piano peripheral. The CPU writes 16-bit commands into a FIFO.
//  A dispatcher routes each command to one of NUM_CHANNELS square-wave voices, each with its own note duration.

---
 rtl/piano_synth_poly.sv | 250 +++++++++++++++++++++++++
 tb/tb_piano_synth_poly.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/piano_synth_poly.sv
// Polyphonic square-wave piano peripheral: a command FIFO, an in-order dispatcher,
// NUM_CHANNELS independent voices and a PWM mixer driving the single speaker pin.

module piano_synth_voice #(
   parameter int unsigned HALF_W          = 20,
   parameter int unsigned DUR_UNIT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              kill,
   input  logic [HALF_W-1:0] half_in,
   input  logic              rest_in,
   input  logic [5:0]        dur_in,
   output logic              busy,
   output logic              finite,
   output logic              audible
);
   localparam int unsigned     PRE_W   = (DUR_UNIT_CYCLES > 1) ? $clog2(DUR_UNIT_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DUR_UNIT_CYCLES - 1);

   logic              busy_q, busy_d, rest_q, rest_d, inf_q, inf_d, sq_q, sq_d;
   logic [HALF_W-1:0] half_q, half_d, phase_q, phase_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [5:0]        units_q, units_d;

   always_comb begin
      busy_d  = busy_q;
      rest_d  = rest_q;
      inf_d   = inf_q;
      sq_d    = sq_q;
      half_d  = half_q;
      phase_d = phase_q;
      pre_d   = pre_q;
      units_d = units_q;
      if (kill) begin
         busy_d = 1'b0;
         sq_d   = 1'b0;
      end else if (load) begin
         busy_d  = 1'b1;
         rest_d  = rest_in;
         inf_d   = (dur_in == 6'd0);
         sq_d    = 1'b1;
         half_d  = half_in;
         phase_d = '0;
         pre_d   = '0;
         units_d = dur_in;
      end else if (busy_q) begin
         // rests keep the phase counter parked so it never wraps
         if (!rest_q) begin
            if (phase_q == half_q - HALF_W'(1)) begin
               phase_d = '0;
               sq_d    = ~sq_q;
            end else begin
               phase_d = phase_q + HALF_W'(1);
            end
         end
         if (!inf_q) begin
            if (pre_q == PRE_MAX) begin
               pre_d   = '0;
               units_d = units_q - 6'd1;
               if (units_q == 6'd1) begin
                  busy_d = 1'b0;
                  sq_d   = 1'b0;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         rest_q  <= 1'b0;
         inf_q   <= 1'b0;
         sq_q    <= 1'b0;
         half_q  <= '0;
         phase_q <= '0;
         pre_q   <= '0;
         units_q <= '0;
      end else begin
         busy_q  <= busy_d;
         rest_q  <= rest_d;
         inf_q   <= inf_d;
         sq_q    <= sq_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         pre_q   <= pre_d;
         units_q <= units_d;
      end
   end

   assign busy    = busy_q;
   assign finite  = busy_q & ~inf_q;
   assign audible = busy_q & ~rest_q & sq_q;
endmodule

module piano_synth_poly #(
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned CLK_HZ          = 100000000,
   parameter int unsigned DUR_UNIT_CYCLES = 1000000
) (
   input  logic                        iFpgaClock,
   input  logic                        iCpuResetN,
   input  logic                        iDoPianoWrite,
   input  logic [15:0]                 iPianoDataToWrite,
   input  logic                        iClearOverflow,
   output logic [$clog2(FIFO_DEPTH):0] oFifoCount,
   output logic                        oFifoFull,
   output logic                        oOverflow,
   output logic [NUM_CHANNELS-1:0]     oChannelBusy,
   output logic                        oFpgaSpeaker
);
   // Half period in clocks of semitone s of octave 2 (A2 = 110 Hz), rounded.
   function automatic int unsigned base_half(input int unsigned s);
      real f;
      f = 110.0 * $pow(2.0, (real'(s) - 9.0) / 12.0);
      return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
   endfunction

   localparam int unsigned HALF_W = $clog2(base_half(0) + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned P_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic [HALF_W-1:0] base_tbl [12];
   for (genvar g = 0; g < 12; g++) begin : g_base
      assign base_tbl[g] = HALF_W'(base_half(g));
   end

   logic [15:0]       fifo_q [FIFO_DEPTH];
   logic [15:0]       fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d, spk_q, spk_d;
   logic [P_W-1:0]    p_q, p_d;

   logic [15:0]       head;
   logic [5:0]        note_m1;
   logic [3:0]        semi, fin4, load4, stop4;
   logic [2:0]        oct, k;
   logic              stop_all, push_req, push, pop, full, ch_ok, rest_sel;
   logic [HALF_W-1:0] half_sel;
   logic [NUM_CHANNELS-1:0] load_vec, kill_vec, v_busy, v_finite, v_audible;

   always_comb begin
      head     = fifo_q[rd_ptr_q];
      full     = (cnt_q == CNT_W'(FIFO_DEPTH));
      stop_all = iDoPianoWrite && (iPianoDataToWrite[15:14] == 2'b10);
      push_req = iDoPianoWrite && !stop_all;
      push     = push_req && !full;
      ch_ok    = ({30'd0, head[13:12]} < NUM_CHANNELS);
      fin4     = 4'(v_finite);
      note_m1  = head[11:6] - 6'd1;
      semi     = 4'(note_m1 % 6'd12);
      oct      = 3'(note_m1 / 6'd12);
      rest_sel = (head[11:6] == 6'd0) || (head[11:6] > 6'd60);
      half_sel = base_tbl[semi] >> oct;

      // head-of-line dispatch: a PLAY waits only on a voice with finite time left
      pop   = 1'b0;
      load4 = 4'd0;
      stop4 = 4'd0;
      if (cnt_q != '0 && !stop_all) begin
         if (head[15:14] == 2'b00 && ch_ok) begin
            if (!fin4[head[13:12]]) begin
               pop   = 1'b1;
               load4 = 4'd1 << head[13:12];
            end
         end else if (head[15:14] == 2'b01 && ch_ok) begin
            pop   = 1'b1;
            stop4 = 4'd1 << head[13:12];
         end else begin
            pop = 1'b1;
         end
      end
      load_vec = load4[NUM_CHANNELS-1:0];
      kill_vec = stop4[NUM_CHANNELS-1:0] | {NUM_CHANNELS{stop_all}};

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (stop_all) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = iPianoDataToWrite;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      ovf_d = ovf_q;
      if (iClearOverflow) ovf_d = 1'b0;
      if (push_req && full) ovf_d = 1'b1;

      k     = 3'($countones(v_audible));
      p_d   = ({{(32-P_W){1'b0}}, p_q} == NUM_CHANNELS - 1) ? '0 : p_q + P_W'(1);
      spk_d = (3'(p_q) < k);
   end

   piano_synth_voice #(
      .HALF_W          (HALF_W),
      .DUR_UNIT_CYCLES (DUR_UNIT_CYCLES)
   ) u_voice [NUM_CHANNELS-1:0] (
      .clk     (iFpgaClock),
      .rst_n   (iCpuResetN),
      .load    (load_vec),
      .kill    (kill_vec),
      .half_in (half_sel),
      .rest_in (rest_sel),
      .dur_in  (head[5:0]),
      .busy    (v_busy),
      .finite  (v_finite),
      .audible (v_audible)
   );

   always_ff @(posedge iFpgaClock or negedge iCpuResetN) begin
      if (!iCpuResetN) begin
         fifo_q   <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         p_q      <= '0;
         spk_q    <= 1'b0;
      end else begin
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         p_q      <= p_d;
         spk_q    <= spk_d;
      end
   end

   assign oFifoCount   = cnt_q;
   assign oFifoFull    = full;
   assign oOverflow    = ovf_q;
   assign oChannelBusy = v_busy;
   assign oFpgaSpeaker = spk_q;
endmodule

// File: tb/tb_piano_synth_poly.sv
// Directed bench for piano_synth_poly: 4-, 2- and 1-voice instances share one command stream.
// The 1-voice instance exposes the raw square wave on its speaker pin.
module tb_piano_synth_poly;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] data = 16'd0;
   logic        clr = 1'b0;

   logic [3:0] cnt4, cnt2, cnt1;
   logic       full4, full2, full1, ovf4, ovf2, ovf1, spk4, spk2, spk1;
   logic [3:0] busy4;
   logic [1:0] busy2;
   logic [0:0] busy1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   piano_synth_poly #(.NUM_CHANNELS(4), .FIFO_DEPTH(8), .CLK_HZ(100000000), .DUR_UNIT_CYCLES(100)) u_dut4 (
      .iFpgaClock(clk), .iCpuResetN(rst_n), .iDoPianoWrite(wr), .iPianoDataToWrite(data),
      .iClearOverflow(clr), .oFifoCount(cnt4), .oFifoFull(full4), .oOverflow(ovf4),
      .oChannelBusy(busy4), .oFpgaSpeaker(spk4));
   piano_synth_poly #(.NUM_CHANNELS(2), .FIFO_DEPTH(8), .CLK_HZ(100000000), .DUR_UNIT_CYCLES(100)) u_dut2 (
      .iFpgaClock(clk), .iCpuResetN(rst_n), .iDoPianoWrite(wr), .iPianoDataToWrite(data),
      .iClearOverflow(clr), .oFifoCount(cnt2), .oFifoFull(full2), .oOverflow(ovf2),
      .oChannelBusy(busy2), .oFpgaSpeaker(spk2));
   piano_synth_poly #(.NUM_CHANNELS(1), .FIFO_DEPTH(8), .CLK_HZ(100000000), .DUR_UNIT_CYCLES(100)) u_dut1 (
      .iFpgaClock(clk), .iCpuResetN(rst_n), .iDoPianoWrite(wr), .iPianoDataToWrite(data),
      .iClearOverflow(clr), .oFifoCount(cnt1), .oFifoFull(full1), .oOverflow(ovf1),
      .oChannelBusy(busy1), .oFpgaSpeaker(spk1));

   typedef struct {
      logic        wr;
      logic [15:0] data;
      logic        clr;
      int          cnt;
      logic        full;
      logic        ovf;
      logic [3:0]  busy;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_b[$];

   function automatic vec_t mk(input logic w, input logic [15:0] d, input logic c, input int n,
                               input logic f, input logic o, input logic [3:0] b);
      vec_t v;
      v.wr = w; v.data = d; v.clr = c; v.cnt = n; v.full = f; v.ovf = o; v.busy = b;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic write(input logic [15:0] d);
      wr = 1'b1;
      data = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      wr = v.wr; data = v.data; clr = v.clr;
      tick();
      wr = 1'b0; clr = 1'b0;
      chk($sformatf("%s[%0d] count", tag, idx), int'(cnt4), v.cnt);
      chk($sformatf("%s[%0d] full", tag, idx), int'(full4), int'(v.full));
      chk($sformatf("%s[%0d] overflow", tag, idx), int'(ovf4), int'(v.ovf));
      chk($sformatf("%s[%0d] busy", tag, idx), int'(busy4), int'(v.busy));
   endtask

   // PLAY ch0 note10 dur3: 300 busy cycles, square stays high (half=454545)
   task automatic run_t1(input string tag);
      int nb4, nb1, ns1, ns4;
      write(16'h0283);
      chk({tag, " queued count"}, int'(cnt4), 1);
      chk({tag, " queued busy"}, int'(busy4), 0);
      tick();
      chk({tag, " dispatched count"}, int'(cnt4), 0);
      chk({tag, " dispatched busy"}, int'(busy4), 1);
      chk({tag, " spk1 at load"}, int'(spk1), 0);
      nb4 = int'(busy4[0]); nb1 = int'(busy1[0]); ns1 = int'(spk1); ns4 = int'(spk4);
      for (int i = 0; i < 310; i++) begin
         tick();
         nb4 += int'(busy4[0]); nb1 += int'(busy1[0]); ns1 += int'(spk1); ns4 += int'(spk4);
      end
      chk({tag, " busy cycles 4ch"}, nb4, 300);
      chk({tag, " busy cycles 1ch"}, nb1, 300);
      chk({tag, " square high cycles 1ch"}, ns1, 300);
      chk({tag, " pwm ones 4ch"}, ns4, 75);
   endtask

   initial begin : main
      int run, gap, ones;
      logic [3:0] pat, pat2;

      tab_a.push_back(mk(1'b1, 16'h1280, 1'b0, 1, 1'b0, 1'b0, 4'b0000));
      tab_a.push_back(mk(1'b1, 16'h2580, 1'b0, 1, 1'b0, 1'b0, 4'b0010));
      tab_a.push_back(mk(1'b1, 16'h0005, 1'b0, 1, 1'b0, 1'b0, 4'b0110));
      tab_a.push_back(mk(1'b1, 16'h0001, 1'b0, 1, 1'b0, 1'b0, 4'b0111));
      for (int i = 2; i <= 5; i++) tab_a.push_back(mk(1'b1, 16'h0001, 1'b0, i, 1'b0, 1'b0, 4'b0111));

      tab_b.push_back(mk(1'b1, 16'h0001, 1'b0, 1, 1'b0, 1'b0, 4'b0000));
      tab_b.push_back(mk(1'b1, 16'h0001, 1'b0, 1, 1'b0, 1'b0, 4'b0001));
      for (int i = 2; i <= 8; i++) tab_b.push_back(mk(1'b1, 16'(i), 1'b0, i, (i == 8), 1'b0, 4'b0001));
      tab_b.push_back(mk(1'b1, 16'h0009, 1'b0, 8, 1'b1, 1'b1, 4'b0001));
      tab_b.push_back(mk(1'b0, 16'h0000, 1'b1, 8, 1'b1, 1'b0, 4'b0001));
      tab_b.push_back(mk(1'b1, 16'h0009, 1'b1, 8, 1'b1, 1'b1, 4'b0001));
      tab_b.push_back(mk(1'b0, 16'h0000, 1'b1, 8, 1'b1, 1'b0, 4'b0001));

      // reset state
      #22;
      chk("reset count", int'(cnt4), 0);
      chk("reset flags", int'({full4, ovf4, spk4, spk1, busy1}), 0);
      chk("reset busy", int'(busy4), 0);
      rst_n = 1'b1;
      tick();

      run_t1("t1");

      // note46 indefinite on the 1-voice instance: half = 56818
      write(16'h0B80);
      tick();
      chk("t2 spk at load", int'(spk1), 0);
      chk("t2 busy", int'(busy1), 1);
      run = 0;
      for (int i = 0; i < 60000; i++) begin
         tick();
         if (spk1) run++;
         else break;
      end
      chk("t2 half period", run, 56818);
      write(16'h0280);
      tick();
      chk("t2 preempt load spk", int'(spk1), 0);
      tick();
      chk("t2 phase restart spk", int'(spk1), 1);
      ones = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         ones += int'(spk1);
      end
      chk("t2 new note high", ones, 200);
      write(16'h4000);
      chk("t2 stop queued busy", int'(busy1), 1);
      tick();
      chk("t2 stop busy", int'(busy1), 0);
      tick();
      chk("t2 stop spk", int'(spk1), 0);

      foreach (tab_a[i]) apply(tab_a[i], "t4", i);

      // two voices high (ch1, ch2), ch0 rest: duty 2/4
      for (int i = 0; i < 4; i++) begin tick(); pat[3-i] = spk4; end
      for (int i = 0; i < 4; i++) begin tick(); pat2[3-i] = spk4; end
      chk("t5 duty pattern", int'(pat == 4'b1100 || pat == 4'b0110 || pat == 4'b0011 || pat == 4'b1001), 1);
      chk("t5 pattern repeats", int'(pat2), int'(pat));

      write(16'h8000);
      chk("t4 stopall count", int'(cnt4), 0);
      chk("t4 stopall busy", int'(busy4), 0);
      chk("t4 stopall count 1ch", int'(cnt1), 0);
      repeat (4) tick();
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         ones += int'(spk4);
      end
      chk("t4 speaker silent", ones, 0);

      // discard paths on the 2-voice instance
      write(16'hC283);
      chk("t5 op11 queued", int'(cnt2), 1);
      write(16'h2283);
      chk("t5 ch2 queued", int'(cnt2), 1);
      write(16'h3283);
      chk("t5 ch3 queued", int'(cnt2), 1);
      tick();
      chk("t5 drained", int'(cnt2), 0);
      chk("t5 no voice", int'(busy2), 0);
      write(16'h1280);
      tick();
      chk("t5 ch1 plays", int'(busy2), 2);
      chk("t5 4ch busy", int'(busy4), 4'b1110);
      write(16'h5000);
      tick();
      chk("t5 stop ch1 2ch", int'(busy2), 0);
      chk("t5 stop ch1 4ch", int'(busy4), 4'b1100);
      write(16'h8000);
      chk("t5 stopall busy", int'(busy4), 0);

      foreach (tab_b[i]) apply(tab_b[i], "t3", i);

      run = 0;
      while (busy4[0] && run < 500) begin tick(); run++; end
      chk("t3 first note ends", int'(busy4[0]), 0);
      for (int n = 1; n <= 8; n++) begin
         gap = 0;
         while (!busy4[0] && gap < 10) begin tick(); gap++; end
         chk($sformatf("t3 gap before %0d", n), gap, 1);
         run = 0;
         while (busy4[0] && run < 1000) begin run++; tick(); end
         chk($sformatf("t3 drain order %0d", n), run, n * 100);
      end
      repeat (3) tick();
      chk("t3 dropped write absent", int'(busy4), 0);
      chk("t3 empty", int'(cnt4), 0);

      // async reset between edges
      write(16'h0283);
      repeat (5) tick();
      chk("t6 playing", int'(spk1), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6 reset busy", int'(busy4), 0);
      chk("t6 reset flags", int'({full4, ovf4, spk4, spk1, busy1}), 0);
      chk("t6 reset count", int'(cnt4), 0);
      #10 rst_n = 1'b1;
      tick();
      tick();
      run_t1("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
